// File: rtl/psum_drain_if.sv
// psum_drain_if: row stream from the south-edge collector to its downstream consumer.
interface psum_drain_if #(
   parameter int N  = 4,
   parameter int DW = 32
);
   logic            out_valid;
   logic [N*DW-1:0] out_data;
   logic            out_last;
   logic            out_ready;

   modport master(output out_valid, out_data, out_last, input out_ready);
   modport slave(input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/psum_drain.sv
// psum_drain: de-skews bottom-row partial sums into result rows and streams them out via a FIFO.
module psum_drain #(
   parameter int N         = 4,
   parameter int DW        = 32,
   parameter int M         = 4,
   parameter int FIRST_LAT = 4,
   parameter int DEPTH     = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            compute,
   input  logic [N*DW-1:0] col_in,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic            overflow,
   psum_drain_if.master    drain
);
   localparam int CW = $clog2(FIRST_LAT + M + N + 1);
   localparam int SW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;

   state_t          st, st_d;
   logic [CW-1:0]   cnt, cnt_d, pr;
   logic [SW-1:0]   pslot;
   logic            cap, push, wr, pop, last_d;
   logic [N*DW-1:0] push_data;
   logic [DW-1:0]   asm_q [N][N];
   logic [N*DW:0]   mem [DEPTH];
   logic [AW-1:0]   wp, rp;
   logic [AW:0]     count;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st  <= IDLE;
         cnt <= '0;
      end else begin
         st  <= st_d;
         cnt <= cnt_d;
      end

   // cnt counts latency cycles in WAIT and the capture column-skew index c in CAPTURE
   always_comb begin
      st_d  = st;
      cnt_d = cnt;
      if (st == IDLE && start) begin
         st_d  = (FIRST_LAT == 0) ? CAPTURE : WAIT;
         cnt_d = '0;
      end else if (st == WAIT && compute) begin
         st_d  = (cnt == CW'(FIRST_LAT - 1)) ? CAPTURE : WAIT;
         cnt_d = (cnt == CW'(FIRST_LAT - 1)) ? '0 : cnt + 1'b1;
      end else if (st == CAPTURE && compute) begin
         st_d  = (cnt == CW'(M + N - 2)) ? IDLE : CAPTURE;
         cnt_d = (cnt == CW'(M + N - 2)) ? '0 : cnt + 1'b1;
      end
   end

   always_comb begin
      cap    = st == CAPTURE && compute;
      pr     = cnt - CW'(N - 1);
      pslot  = SW'(pr % CW'(N));
      push   = cap && cnt >= CW'(N - 1) && pr < CW'(M);
      last_d = pr == CW'(M - 1);
      done   = cap && cnt == CW'(M + N - 2);
      busy   = st != IDLE;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               asm_q[i][j] <= '0;
      end else if (cap) begin
         for (int j = 0; j < N; j++)
            if (cnt >= CW'(j) && cnt - CW'(j) < CW'(M))
               asm_q[SW'((cnt - CW'(j)) % CW'(N))][j] <= col_in[j*DW +: DW];
      end

   // the last column completes its row in the push cycle, so it bypasses the buffer
   for (genvar j = 0; j < N; j++) begin : g_col
      if (j == N - 1) begin : g_byp
         assign push_data[j*DW +: DW] = col_in[j*DW +: DW];
      end else begin : g_buf
         assign push_data[j*DW +: DW] = asm_q[pslot][j];
      end
   end

   assign stall = count == (AW + 1)'(DEPTH);
   assign pop   = drain.out_valid && drain.out_ready;
   assign wr    = push && (!stall || pop);

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         count    <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
         overflow <= overflow | (push && stall && !pop);
      end

   always_ff @(posedge clk)
      if (wr) mem[wp] <= {last_d, push_data};

   assign drain.out_valid = count != '0;
   assign drain.out_data  = drain.out_valid ? mem[rp][N*DW-1:0] : '0;
   assign drain.out_last  = drain.out_valid && mem[rp][N*DW];
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed tiles against hand-computed rows {100r+j}, done timing and FIFO limits.
module tb_psum_drain;
   logic         clk, rst, start, compute, ready, rdy2;
   logic [127:0] col_in;
   logic         stall, busy, done, overflow;
   logic         stall2, busy2, done2, ovf2;
   logic [128:0] got[$];
   int           n_cmp, n_bad, k, cyc_i, done_k, done_cyc, n_done;
   bit           track, busy_gap;

   psum_drain_if #(.N(4), .DW(32)) ifc();
   psum_drain_if #(.N(4), .DW(32)) ifc2();
   assign ifc.out_ready  = ready;
   assign ifc2.out_ready = rdy2;

   psum_drain #(.N(4), .DW(32), .M(4), .FIRST_LAT(4), .DEPTH(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .compute(compute), .col_in(col_in),
      .stall(stall), .busy(busy), .done(done), .overflow(overflow), .drain(ifc));

   psum_drain #(.N(4), .DW(32), .M(4), .FIRST_LAT(4), .DEPTH(2)) u_d2 (
      .clk(clk), .rst(rst), .start(start), .compute(compute), .col_in(col_in),
      .stall(stall2), .busy(busy2), .done(done2), .overflow(ovf2), .drain(ifc2));

   initial clk = 0;
   always #5 clk = ~clk;

   always @(negedge clk)
      if (!rst && ifc.out_valid && ifc.out_ready) got.push_back({ifc.out_last, ifc.out_data});

   task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] exp_row(input int r);
      logic [127:0] v;
      for (int j = 0; j < 4; j++) v[j*32 +: 32] = 32'(100 * r + j);
      return v;
   endfunction

   // column j carries row k-4-j at compute cycle k; outside the tile window it is junk
   function automatic logic [127:0] col_pat(input int kk);
      logic [127:0] v;
      for (int j = 0; j < 4; j++) begin
         int r = kk - 4 - j;
         v[j*32 +: 32] = (r >= 0 && r < 4) ? 32'(100 * r + j) : (32'hBAD00000 | 32'(kk));
      end
      return v;
   endfunction

   task automatic step(input bit c, input bit s);
      start   = s;
      compute = c;
      col_in  = c ? col_pat(k) : '1;
      @(negedge clk);
      if (done) begin
         n_done++;
         done_k   = k;
         done_cyc = cyc_i;
      end
      if (track && !busy) busy_gap = 1;
      @(posedge clk);
      #1;
      if (c) k++;
      cyc_i++;
      start = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0);
   endtask

   task automatic run_tile(input int lows, input bit mid_start);
      int  nd0, left;
      bit  prev;
      step(0, 1);
      k        = 0;
      cyc_i    = 0;
      nd0      = n_done;
      track    = 1;
      busy_gap = 0;
      prev     = 0;
      left     = lows;
      for (int t = 0; t < 60 && n_done == nd0; t++) begin
         bit c;
         c = !(left > 0 && k >= 4 && prev);
         if (!c) left--;
         step(c, mid_start && c && k == 6);
         prev = c;
      end
      track = 0;
      chk("done_count", n_done - nd0, 1);
      chk("done_cycle", done_k, 10);
      chk("done_clk", done_cyc, 10 + lows);
      chk("busy_gap", busy_gap, 0);
      chk("busy_after", busy, 0);
   endtask

   task automatic check_rows(input int n);
      chk("nrows", got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++) begin
         chk("row", got[i][127:0], exp_row(i % 4));
         chk("last", got[i][128], (i % 4) == 3);
      end
      got.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, ifc.out_valid, 0);
      chk({tag, "_data"}, ifc.out_data, 0);
      chk({tag, "_stall"}, stall, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_ovf"}, overflow, 0);
   endtask

   initial begin
      int nd0;
      rst = 1; start = 0; compute = 0; col_in = '0; ready = 1; rdy2 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 0;
      idle(1);

      // T1 + T4 (DEPTH=2 instance never ready during this tile)
      run_tile(0, 0);
      idle(3);
      check_rows(4);
      chk("t1_ovf", overflow, 0);
      chk("t4_ovf", ovf2, 1);
      chk("t4_stall", stall2, 1);
      chk("t4_row0", ifc2.out_data, exp_row(0));
      chk("t4_last0", ifc2.out_last, 0);
      rdy2 = 1;
      step(0, 0);
      rdy2 = 0;
      chk("t4_row1", ifc2.out_data, exp_row(1));
      chk("t4_last1", ifc2.out_last, 0);
      rdy2 = 1;

      // T2: backpressure fills the FIFO exactly
      ready = 0;
      run_tile(0, 0);
      chk("t2_stall", stall, 1);
      chk("t2_ovf", overflow, 0);
      chk("t2_none", got.size(), 0);
      chk("t2_head", ifc.out_data, exp_row(0));
      ready = 1;
      idle(6);
      check_rows(4);
      chk("t2_stall_off", stall, 0);

      // T3: compute gaps during capture
      run_tile(2, 0);
      idle(3);
      check_rows(4);

      // T5: stray start mid-capture, then back-to-back tile
      run_tile(0, 1);
      run_tile(0, 0);
      idle(3);
      check_rows(8);
      chk("t5_ovf", overflow, 0);

      // T6: reset at compute cycle 7
      step(0, 1);
      k   = 0;
      nd0 = n_done;
      for (int t = 0; t < 20 && k < 7; t++) step(1, 0);
      compute = 1;
      col_in  = col_pat(k);
      rst     = 1;
      #1;
      chk_zero("t6");
      @(posedge clk);
      #1;
      rst     = 0;
      compute = 0;
      chk("t6_nodone", n_done - nd0, 0);
      idle(2);
      chk("t6_empty", got.size(), 0);
      run_tile(0, 0);
      idle(3);
      check_rows(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
